// File: rtl/kbd_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : kbd_fifo_if
// Purpose  : I/O bus bundle for the PS/2 keyboard controller.
// Ports    : en       bus select
//            wr       1 = write, 0 = read
//            addr     register select (0 = status/control, 1 = data)
//            data_in  write data
//            data_out read data (combinational)
//            wt       wait (always 0)
//            irq      level interrupt
// Revision : 1.0  initial release
// ============================================================================
interface kbd_fifo_if;
   logic       en;
   logic       wr;
   logic       addr;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       wt;
   logic       irq;

   modport master (
      output en, wr, addr, data_in,
      input  data_out, wt, irq
   );

   modport slave (
      input  en, wr, addr, data_in,
      output data_out, wt, irq
   );
endinterface
`default_nettype wire

// File: rtl/kbd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : kbd_fifo
// Purpose  : PS/2 keyboard controller. Synchronises and filters the PS/2
//            clock, receives 11-bit frames (start, 8 data LSB first, parity,
//            stop) with a receive timeout, and queues scan codes in a FIFO of
//            2^DEPTH_LOG2 bytes read over the I/O bus.
// Params   : DEPTH_LOG2  FIFO depth exponent (1..8)
//            FILTER      equal samples needed to move the filtered clock
//            TIMEOUT     idle cycles before a partial frame is aborted
// Ports    : clk        system clock
//            reset      synchronous, active-high
//            ps2_clk    PS/2 clock pin (asynchronous)
//            ps2_data   PS/2 data pin (asynchronous)
//            bus        kbd_fifo_if.slave I/O bus
// Options  : KBD_PARITY_CHECK_EN  when defined, odd parity is checked and a
//            mismatch sets the sticky perr flag; otherwise parity is ignored.
// Revision : 1.0  initial release
// ============================================================================
module kbd_fifo #(
   parameter int DEPTH_LOG2 = 4,
   parameter int FILTER     = 8,
   parameter int TIMEOUT    = 50000
) (
   input  wire logic clk,
   input  wire logic reset,
   input  wire logic ps2_clk,
   input  wire logic ps2_data,
   kbd_fifo_if.slave bus
);

   localparam int                    c_DEPTH     = 1 << DEPTH_LOG2;
   localparam int                    c_TO_W      = $clog2(TIMEOUT + 1);
   localparam logic [c_TO_W-1:0]     c_TO_LAST   = c_TO_W'(TIMEOUT - 1);
   localparam logic [7:0]            c_FILT_LAST = 8'(FILTER - 1);
   localparam logic [DEPTH_LOG2:0]   c_FULL      = (DEPTH_LOG2 + 1)'(c_DEPTH);
   localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE   = DEPTH_LOG2'(1);
   localparam logic [DEPTH_LOG2:0]   c_CNT_ONE   = (DEPTH_LOG2 + 1)'(1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // Two-flop synchronisers; reset to the idle (high) bus level
   // ------------------------------------------------------------------
   logic r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_clk_s1 <= 1'b1;
         r_clk_s2 <= 1'b1;
         r_dat_s1 <= 1'b1;
         r_dat_s2 <= 1'b1;
      end else begin
         r_clk_s1 <= ps2_clk;
         r_clk_s2 <= r_clk_s1;
         r_dat_s1 <= ps2_data;
         r_dat_s2 <= r_dat_s1;
      end
   end

   // ------------------------------------------------------------------
   // Clock filter: the counter tracks consecutive samples at the
   // candidate (opposite) level and restarts whenever the sample agrees
   // with the current filtered level.
   // ------------------------------------------------------------------
   logic [7:0] r_fcnt;
   logic       r_fclk;
   logic       r_fall;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fcnt <= 8'd0;
         r_fclk <= 1'b1;
         r_fall <= 1'b0;
      end else begin
         r_fall <= 1'b0;
         if (r_clk_s2 != r_fclk) begin
            if (r_fcnt == c_FILT_LAST) begin
               r_fclk <= r_clk_s2;
               r_fcnt <= 8'd0;
               r_fall <= ~r_clk_s2;
            end else begin
               r_fcnt <= r_fcnt + 8'd1;
            end
         end else begin
            r_fcnt <= 8'd0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Receiver FSM
   // ------------------------------------------------------------------
   state_t            r_state, w_state;
   logic [2:0]        r_bitcnt, w_bitcnt;
   logic [7:0]        r_shift, w_shift;
   logic [c_TO_W-1:0] r_tocnt, w_tocnt;
   logic              w_push, w_perr_set, w_par_ok;
   logic              r_push;
   logic [7:0]        r_push_byte;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_bitcnt    <= 3'd0;
         r_shift     <= 8'd0;
         r_tocnt     <= '0;
         r_push      <= 1'b0;
         r_push_byte <= 8'd0;
      end else begin
         r_state  <= w_state;
         r_bitcnt <= w_bitcnt;
         r_shift  <= w_shift;
         r_tocnt  <= w_tocnt;
         // Push is staged one cycle so the FIFO write lands at N+1.
         r_push   <= w_push;
         if (w_push) begin
            r_push_byte <= r_shift;
         end
      end
   end

   always_comb begin
      w_state    = r_state;
      w_bitcnt   = r_bitcnt;
      w_shift    = r_shift;
      w_tocnt    = r_tocnt;
      w_push     = 1'b0;
      w_perr_set = 1'b0;
      if (r_state == S_IDLE) begin
         w_tocnt = '0;
         if (r_fall && !r_dat_s2) begin
            w_state  = S_DATA;
            w_bitcnt = 3'd0;
         end
      end else if (r_fall) begin
         w_tocnt = '0;
         case (r_state)
            S_DATA: begin
               w_shift  = {r_dat_s2, r_shift[7:1]};
               w_bitcnt = r_bitcnt + 3'd1;
               if (r_bitcnt == 3'd7) begin
                  w_state = S_PARITY;
               end
            end
            S_PARITY: begin
               w_state = S_STOP;
            end
            default: begin
               // Stop bit: a low stop bit is a framing error, dropped silently.
               w_push     = r_dat_s2 & w_par_ok;
               w_perr_set = r_dat_s2 & ~w_par_ok;
               w_state    = S_IDLE;
            end
         endcase
      end else if (r_tocnt == c_TO_LAST) begin
         w_state = S_IDLE;
         w_tocnt = '0;
      end else begin
         w_tocnt = r_tocnt + c_TO_W'(1);
      end
   end

   // ------------------------------------------------------------------
   // FIFO and bus decode
   // ------------------------------------------------------------------
   logic [7:0]            r_mem [c_DEPTH];
   logic [DEPTH_LOG2-1:0] r_wp, r_rp;
   logic [DEPTH_LOG2:0]   r_cnt;
   logic                  r_ien, r_ovr, w_perr;
   logic                  w_empty, w_full, w_pop, w_ctl_wr, w_flush;
   logic                  w_push_ok, w_ovr_set;
   logic [7:0]            w_dout;

   assign w_empty   = (r_cnt == '0);
   assign w_full    = (r_cnt == c_FULL);
   assign w_pop     = bus.en & ~bus.wr & bus.addr & ~w_empty;
   assign w_ctl_wr  = bus.en & bus.wr & ~bus.addr;
   assign w_flush   = w_ctl_wr & bus.data_in[2];
   // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
   assign w_push_ok = r_push & ~w_flush & (~w_full | w_pop);
   assign w_ovr_set = r_push & ~w_flush & w_full & ~w_pop;

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wp] <= r_push_byte;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || w_flush) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push_ok) begin
            r_wp <= r_wp + c_PTR_ONE;
         end
         if (w_pop) begin
            r_rp <= r_rp + c_PTR_ONE;
         end
         if (w_push_ok && !w_pop) begin
            r_cnt <= r_cnt + c_CNT_ONE;
         end else if (!w_push_ok && w_pop) begin
            r_cnt <= r_cnt - c_CNT_ONE;
         end
      end
   end

   // Clear wins over a same-cycle set so a cleared bit always reads 0 next.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ien <= 1'b0;
         r_ovr <= 1'b0;
      end else begin
         if (w_ctl_wr) begin
            r_ien <= bus.data_in[1];
         end
         if (w_ctl_wr && bus.data_in[3]) begin
            r_ovr <= 1'b0;
         end else if (w_ovr_set) begin
            r_ovr <= 1'b1;
         end
      end
   end

`ifdef KBD_PARITY_CHECK_EN
   logic r_par;
   logic r_perr;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_par <= 1'b0;
      end else if (r_fall && (r_state == S_PARITY)) begin
         r_par <= r_dat_s2;
      end
   end

   // Odd parity: data bits plus parity bit must hold an odd number of ones.
   assign w_par_ok = ^{r_shift, r_par};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_perr <= 1'b0;
      end else if (w_ctl_wr && bus.data_in[4]) begin
         r_perr <= 1'b0;
      end else if (w_perr_set) begin
         r_perr <= 1'b1;
      end
   end

   assign w_perr = r_perr;

   logic w_unused;
   assign w_unused = &{1'b0, bus.data_in[7:5], bus.data_in[0]};
`else
   assign w_par_ok = 1'b1;
   assign w_perr   = 1'b0;

   logic w_unused;
   assign w_unused = &{1'b0, bus.data_in[7:4], bus.data_in[0], w_perr_set};
`endif

   always_comb begin
      w_dout = {2'b00, w_full, w_perr, r_ovr, 1'b0, r_ien, ~w_empty};
      if (bus.addr) begin
         w_dout = w_empty ? 8'h00 : r_mem[r_rp];
      end
   end

   assign bus.data_out = w_dout;
   assign bus.wt       = 1'b0;
   assign bus.irq      = r_ien & ~w_empty;

endmodule
`default_nettype wire

// File: tb/tb_kbd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_kbd_fifo
// Purpose  : Self-checking bench for kbd_fifo: directed vector table, timing
//            corner sequences and randomized traffic against a queue model.
// Revision : 1.0  initial release
// ============================================================================
module tb_kbd_fifo;

   localparam int DL2   = 2;
   localparam int DEPTH = 1 << DL2;
   localparam int FILT  = 4;
   localparam int TO    = 300;
   localparam int HALF  = FILT + 6;

   localparam int OP_FR = 0;
   localparam int OP_RD = 1;
   localparam int OP_WR = 2;

   typedef struct {
      int         op;
      logic       addr;
      logic [7:0] d;
      logic [7:0] exp;
      logic       exp_irq;
   } vec_t;

   logic clk      = 1'b0;
   logic reset    = 1'b1;
   logic ps2_clk  = 1'b1;
   logic ps2_data = 1'b1;

   kbd_fifo_if bus();

   kbd_fifo #(
      .DEPTH_LOG2 (DL2),
      .FILTER     (FILT),
      .TIMEOUT    (TO)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .bus      (bus.slave)
   );

   always #5 clk = ~clk;

   int   checks   = 0;
   int   failures = 0;
   event ev_stop;

   logic [7:0] model_q[$];
   logic       m_ien, m_ovr, m_perr;
   vec_t       vt[$];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input int op, input logic a, input logic [7:0] d,
                               input logic [7:0] e, input logic i);
      vec_t v;
      v.op = op; v.addr = a; v.d = d; v.exp = e; v.exp_irq = i;
      return v;
   endfunction

   // Bit 0 goes out first; each bit is held through a full PS/2 clock period.
   task automatic send_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = bits[i];
         repeat (HALF) tick();
         ps2_clk = 1'b0;
         if (i == 10) -> ev_stop;
         repeat (HALF) tick();
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      repeat (HALF) tick();
   endtask

   task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
      logic [10:0] bits;
      bits = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
      send_bits(bits, 11);
   endtask

   task automatic bus_rd(input logic a, output logic [7:0] d, output logic irq_o);
      bus.en = 1'b1; bus.wr = 1'b0; bus.addr = a;
      #1;
      d     = bus.data_out;
      irq_o = bus.irq;
      tick();
      bus.en = 1'b0;
   endtask

   task automatic bus_wr(input logic a, input logic [7:0] d);
      bus.en = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.data_in = d;
      tick();
      bus.en = 1'b0; bus.wr = 1'b0;
   endtask

   task automatic m_frame(input logic [7:0] d, input bit badp);
`ifdef KBD_PARITY_CHECK_EN
      if (badp) begin
         m_perr = 1'b1;
         return;
      end
`endif
      if (model_q.size() == DEPTH) m_ovr = 1'b1;
      else model_q.push_back(d);
   endtask

   function automatic logic [7:0] m_status();
      return {2'b00, model_q.size() == DEPTH, m_perr, m_ovr, 1'b0, m_ien,
              model_q.size() != 0};
   endfunction

   logic [7:0] got, wd, expd, popped;
   logic       gi, expi;
   bit         bp;
   int         r;

   initial begin
      bus.en = 1'b0; bus.wr = 1'b0; bus.addr = 1'b0; bus.data_in = 8'h00;
      repeat (3) tick();
      reset = 1'b0;
      tick();

      // Reset state
      bus_rd(1'b0, got, gi);
      chk("reset status", got, 8'h00);
      chk("reset irq", {7'b0, gi}, 8'h00);
      chk("reset wt", {7'b0, bus.wt}, 8'h00);

      // rdy rises exactly two cycles after the stop-bit fall strobe
      fork
         send_frame(8'h1C, 1'b0, 1'b0);
         begin
            @(ev_stop);
            repeat (FILT + 3) tick();
            bus.addr = 1'b0;
            #1;
            chk("rdy at N+1", bus.data_out, 8'h00);
            tick();
            #1;
            chk("rdy at N+2", bus.data_out, 8'h01);
            chk("irq masked", {7'b0, bus.irq}, 8'h00);
         end
      join

      // Directed vector table
      vt.push_back(mk(OP_RD, 1'b0, 8'h00, 8'h01, 1'b0));
      vt.push_back(mk(OP_RD, 1'b1, 8'h00, 8'h1C, 1'b0));
      vt.push_back(mk(OP_RD, 1'b0, 8'h00, 8'h00, 1'b0));
      vt.push_back(mk(OP_WR, 1'b0, 8'h02, 8'h00, 1'b0));
      vt.push_back(mk(OP_FR, 1'b0, 8'h5A, 8'h00, 1'b0));
      vt.push_back(mk(OP_RD, 1'b0, 8'h00, 8'h03, 1'b1));
      vt.push_back(mk(OP_RD, 1'b1, 8'h00, 8'h5A, 1'b1));
      vt.push_back(mk(OP_RD, 1'b0, 8'h00, 8'h02, 1'b0));
      vt.push_back(mk(OP_FR, 1'b0, 8'h11, 8'h00, 1'b0));
      vt.push_back(mk(OP_RD, 1'b0, 8'h00, 8'h03, 1'b1));
      vt.push_back(mk(OP_WR, 1'b0, 8'h00, 8'h00, 1'b0));
      vt.push_back(mk(OP_RD, 1'b0, 8'h00, 8'h01, 1'b0));
      vt.push_back(mk(OP_RD, 1'b1, 8'h00, 8'h11, 1'b0));
      for (int i = 1; i <= 5; i++) vt.push_back(mk(OP_FR, 1'b0, 8'(i), 8'h00, 1'b0));
      vt.push_back(mk(OP_RD, 1'b0, 8'h00, 8'h29, 1'b0));
      for (int i = 1; i <= 4; i++) vt.push_back(mk(OP_RD, 1'b1, 8'h00, 8'(i), 1'b0));
      vt.push_back(mk(OP_RD, 1'b1, 8'h00, 8'h00, 1'b0));
      vt.push_back(mk(OP_RD, 1'b0, 8'h00, 8'h08, 1'b0));
      vt.push_back(mk(OP_WR, 1'b0, 8'h08, 8'h00, 1'b0));
      vt.push_back(mk(OP_RD, 1'b0, 8'h00, 8'h00, 1'b0));
      vt.push_back(mk(OP_FR, 1'b0, 8'hAA, 8'h00, 1'b0));
      vt.push_back(mk(OP_FR, 1'b0, 8'hBB, 8'h00, 1'b0));
      vt.push_back(mk(OP_WR, 1'b0, 8'h04, 8'h00, 1'b0));
      vt.push_back(mk(OP_RD, 1'b0, 8'h00, 8'h00, 1'b0));
      vt.push_back(mk(OP_RD, 1'b1, 8'h00, 8'h00, 1'b0));
      vt.push_back(mk(OP_FR, 1'b0, 8'h44, 8'h00, 1'b0));
      vt.push_back(mk(OP_WR, 1'b1, 8'hFF, 8'h00, 1'b0));
      vt.push_back(mk(OP_RD, 1'b0, 8'h00, 8'h01, 1'b0));
      vt.push_back(mk(OP_RD, 1'b1, 8'h00, 8'h44, 1'b0));
      vt.push_back(mk(OP_RD, 1'b0, 8'h00, 8'h00, 1'b0));

      for (int i = 0; i < vt.size(); i++) begin
         case (vt[i].op)
            OP_FR: send_frame(vt[i].d, 1'b0, 1'b0);
            OP_WR: bus_wr(vt[i].addr, vt[i].d);
            default: begin
               bus_rd(vt[i].addr, got, gi);
               chk($sformatf("vec%0d data", i), got, vt[i].exp);
               chk($sformatf("vec%0d irq", i), {7'b0, gi}, {7'b0, vt[i].exp_irq});
            end
         endcase
      end

      // Full FIFO: a pop in the very cycle the push lands avoids overflow
      for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0, 1'b0);
      fork
         send_frame(8'h05, 1'b0, 1'b0);
         begin
            @(ev_stop);
            repeat (FILT + 3) tick();
            bus.en = 1'b1; bus.wr = 1'b0; bus.addr = 1'b1;
            #1;
            popped = bus.data_out;
            tick();
            bus.en = 1'b0;
         end
      join
      chk("same-cycle pop data", popped, 8'h01);
      bus_rd(1'b0, got, gi);
      chk("same-cycle status", got, 8'h21);
      for (int i = 2; i <= 5; i++) begin
         bus_rd(1'b1, got, gi);
         chk("same-cycle drain", got, 8'(i));
      end

      // Parity error on 0x33
      send_frame(8'h33, 1'b1, 1'b0);
`ifdef KBD_PARITY_CHECK_EN
      bus_rd(1'b0, got, gi);
      chk("perr set", got, 8'h10);
      bus_wr(1'b0, 8'h10);
      bus_rd(1'b0, got, gi);
      chk("perr cleared", got, 8'h00);
`else
      bus_rd(1'b0, got, gi);
      chk("parity ignored status", got, 8'h01);
      bus_rd(1'b1, got, gi);
      chk("parity ignored data", got, 8'h33);
      bus_wr(1'b0, 8'h10);
      bus_rd(1'b0, got, gi);
      chk("perr stays 0", got, 8'h00);
`endif

      // Framing error is dropped silently
      send_frame(8'h66, 1'b0, 1'b1);
      bus_rd(1'b0, got, gi);
      chk("framing status", got, 8'h00);

      // Partial frame aborted by timeout
      send_bits({2'b11, 8'h0A, 1'b0}, 5);
      repeat (TO + 20) tick();
      send_frame(8'h76, 1'b0, 1'b0);
      bus_rd(1'b0, got, gi);
      chk("timeout status", got, 8'h01);
      bus_rd(1'b1, got, gi);
      chk("timeout data", got, 8'h76);

      // Clock glitches shorter than the filter are ignored
      for (int g = 0; g < 3; g++) begin
         ps2_data = 1'b0;
         repeat (2) tick();
         ps2_clk = 1'b0;
         repeat (FILT - 1) tick();
         ps2_clk = 1'b1;
         repeat (HALF) tick();
         ps2_data = 1'b1;
         repeat (2) tick();
      end
      send_frame(8'h76, 1'b0, 1'b0);
      bus_rd(1'b0, got, gi);
      chk("glitch status", got, 8'h01);
      bus_rd(1'b1, got, gi);
      chk("glitch data", got, 8'h76);

      // Reset mid-frame discards the partial byte and control state
      bus_wr(1'b0, 8'h02);
      send_bits({2'b11, 8'h2B, 1'b0}, 7);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus_rd(1'b0, got, gi);
      chk("midreset status", got, 8'h00);
      chk("midreset irq", {7'b0, gi}, 8'h00);
      send_frame(8'h2B, 1'b0, 1'b0);
      bus_rd(1'b1, got, gi);
      chk("midreset data", got, 8'h2B);

      // Randomized traffic against the queue model
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_q.delete();
      m_ien = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
      for (int k = 0; k < 60; k++) begin
         r = $urandom_range(0, 99);
         expi = m_ien & (model_q.size() != 0);
         if (r < 35) begin
            wd = 8'($urandom);
            bp = ($urandom_range(0, 4) == 0);
            send_frame(wd, bp, 1'b0);
            m_frame(wd, bp);
         end else if (r < 65) begin
            bus_rd(1'b1, got, gi);
            expd = (model_q.size() != 0) ? model_q[0] : 8'h00;
            if (model_q.size() != 0) void'(model_q.pop_front());
            chk($sformatf("rand%0d pop", k), got, expd);
            chk($sformatf("rand%0d irq", k), {7'b0, gi}, {7'b0, expi});
         end else if (r < 85) begin
            bus_rd(1'b0, got, gi);
            chk($sformatf("rand%0d status", k), got, m_status());
            chk($sformatf("rand%0d irq", k), {7'b0, gi}, {7'b0, expi});
         end else begin
            wd = 8'($urandom);
            wd[2] = ($urandom_range(0, 5) == 0);
            bus_wr(1'b0, wd);
            m_ien = wd[1];
            if (wd[3]) m_ovr = 1'b0;
`ifdef KBD_PARITY_CHECK_EN
            if (wd[4]) m_perr = 1'b0;
`endif
            if (wd[2]) model_q.delete();
         end
      end
      bus_rd(1'b0, got, gi);
      chk("rand final status", got, m_status());

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/kbd_fifo.md
# kbd_fifo

Parametrised PS/2 keyboard controller for the I/O bus: an integrated PS/2 frame receiver with clock filtering, a receive timeout and odd-parity checking, feeding a scan-code FIFO of configurable depth. The CPU reads status and control at address 0 and pops scan codes at address 1. It raises a level interrupt while enabled and the FIFO is non-empty. It is the successor to the single-byte keyboard controller and keeps the same bus pinout.

## Interface
- DEPTH_LOG2, 4: FIFO holds 2^DEPTH_LOG2 bytes; legal range 1..8.
- FILTER, 8: consecutive equal samples required before the filtered ps2_clk changes; range 2..255.
- TIMEOUT, 50000: clk cycles without a filtered falling edge before a partial frame is aborted.
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high.
- ps2_clk  in  1  PS/2 clock, asynchronous.
- ps2_data  in  1  PS/2 data, asynchronous.
- en  in  1  bus select.
- wr  in  1  1 = write, 0 = read.
- addr  in  1  register select.
- data_in  in  8  write data.
- data_out  out  8  read data, combinational from addr and state.
- wt  out  1  wait; constant 0.
- irq  out  1  ien & rdy.

## Operation
- Status read, addr 0, data_out = {2'b00, cnt_full, perr, ovr, 1'b0, ien, rdy}:
  - rdy: FIFO non-empty.
  - cnt_full: FIFO full.
  - bit 2 always reads 0.
- Status write, addr 0:
  - ien <= data_in[1].
  - data_in[3]=1 clears ovr; data_in[4]=1 clears perr.
  - data_in[2]=1 flushes the FIFO.
  - Cleared bits are 0 from the next cycle.
- Data read, addr 1: data_out = head byte, or 8'h00 if empty. A cycle with en=1, wr=0, addr=1 pops one entry if non-empty. An empty read has no side effect.
- Writes to addr 1 are ignored. A status read has no side effect.
- Synchroniser: ps2_clk and ps2_data each pass through 2 flops.
- Filter: a counter per candidate level; filtered clock changes when FILTER equal samples are seen. A falling edge of the filtered clock is a one-cycle strobe `fall`.
- Receiver FSM; every transition happens on `fall`; data is sampled from synchronised ps2_data:
  - IDLE: data=0 -> DATA with bit counter 0; data=1 stays IDLE.
  - DATA: shift data in LSB first; after bit 7 -> PARITY.
  - PARITY: store parity bit -> STOP.
  - STOP: data=1 and parity OK -> push byte, then IDLE. data=0 (framing error) -> drop the byte silently, then IDLE.
- Timeout: in any state other than IDLE, a counter runs and restarts on each `fall`. Reaching TIMEOUT -> IDLE and the partial byte is discarded. No flag is set.
- Push, FIFO full:
  - If a pop occurs in the same cycle, the push is accepted.
  - Otherwise the byte is dropped and ovr <= 1.
- Push and pop in the same cycle on a non-empty FIFO: both take effect; the count is unchanged.
- Flush and push in the same cycle: flush wins and the pushed byte is discarded.
- FIFO pointers are DEPTH_LOG2 bits and wrap modulo depth. The count is DEPTH_LOG2+1 bits.
- Reset values:
  - FIFO empty, ien=0, ovr=0, perr=0, FSM IDLE, filter and timeout counters 0.
  - Filtered clock = 1.
  - rdy=0, irq=0, data_out=8'h00 at addr 0, wt=0.

## Timing
- data_out and wt are combinational. Pop, flag updates and control writes take effect at the clock edge ending the access cycle.
- If `fall` for the stop bit is asserted in cycle N, the byte is written at the end of N+1. rdy and irq are 1 from cycle N+2.
- Pin-to-`fall` latency is 2 (sync) + FILTER cycles.
- A pop of the last entry at the end of cycle M gives rdy=0 and irq=0 from M+1.
- Reset mid-frame aborts the frame. No byte is pushed from bits received before reset.

## Configuration
- KBD_PARITY_CHECK_EN defined:
  - In STOP, odd parity over the 8 data bits plus the parity bit is checked.
  - Mismatch: byte dropped, perr <= 1 (sticky).
- KBD_PARITY_CHECK_EN not defined:
  - The parity bit is ignored and any well-framed byte is pushed.
  - perr is held at 0 and its clear bit has no effect.

## Test plan
- Reset, then status read -> 8'h00, irq=0. Send frame 0x1C with correct parity -> rdy=1 at N+2. Data read -> 8'h1C, then status = 8'h00.
- Write status 8'h02, then send 0x5A -> irq=1. Pop -> irq=0 the next cycle. Write 8'h00 with data pending -> irq=0, rdy=1.
- DEPTH_LOG2=2: send 5 bytes 0x01..0x05 with no reads -> status = 8'h29 (ovr, full, rdy). Pops return 0x01..0x04, then 8'h00. Write 8'h08 -> ovr cleared.
- Full FIFO with a pop in the same cycle as a push -> no ovr; the new byte is last out.
- Bad parity on 0x33 with macro defined -> no push, perr=1; write 8'h10 clears it. Same frame without macro -> 0x33 pushed.
- Stop ps2_clk after 4 data bits, wait TIMEOUT cycles, then send a full 0x76 -> only 0x76 is received. Glitches on ps2_clk shorter than FILTER cycles -> no bit shifted.
